// File: rtl/fib_rec_seq.sv
// Fibonacci recogniser: iterates F(k) one term per clock until F(k) >= operand, then pulses done with is_fib/fib_idx.
// Latency k_f+1 clocks after capture; start is ignored while busy, accepted in IDLE or DONE.
module fib_rec_seq #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] n_in,
   output logic             busy,
   output logic             done,
   output logic             is_fib,
   output logic [IDX_W-1:0] fib_idx
);

   // Two bits of headroom keep a+b from wrapping while a <= n.
   localparam int AW = WIDTH + 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] n;
   logic [AW-1:0]    a;
   logic [AW-1:0]    b;
   logic [IDX_W-1:0] k;
   logic [AW-1:0]    n_ext;
   logic             accept;
   logic             hit;
   logic             over;

   assign n_ext = {2'b00, n};
   assign hit   = (a == n_ext);
   assign over  = (a > n_ext);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (hit || over) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         is_fib  <= 1'b0;
         fib_idx <= '0;
         n       <= '0;
         a       <= '0;
         b       <= AW'(1);
         k       <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == RUN);
         done  <= (state_nxt == DONE);
         if (accept) begin
            n       <= n_in;
            a       <= '0;
            b       <= AW'(1);
            k       <= '0;
            is_fib  <= 1'b0;
            fib_idx <= '0;
         end else if (state == RUN) begin
            if (hit) begin
               is_fib  <= 1'b1;
               fib_idx <= k;
            end else if (over) begin
               is_fib  <= 1'b0;
               fib_idx <= '0;
            end else begin
               a <= b;
               b <= a + b;
               k <= k + IDX_W'(1);
            end
         end
      end
   end

endmodule
